ex_issue_stage: RTL and testbench

ID/EX pipeline stage that feeds the EX-stage ALU. It latches the decoded instruction, derives the 4-bit ALU control, and forwards results from the EX/MEM and MEM/WB stages onto the ALU operands. It also detects load-use hazards, inserting a one-cycle bubble, and squashes the issuing instruction on a taken-branch flush.

---
 rtl/ex_issue_stage.sv | 156 +++++++++++++++
 tb/tb_ex_issue_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register with ALU-control decode, EX/MEM and MEM/WB operand
// forwarding, load-use stall detection and flush squashing.
module ex_issue_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        IDValid,
  input  logic [31:0] IDPC,
  input  logic [31:0] IDImm,
  input  logic [31:0] IDRs1Data,
  input  logic [31:0] IDRs2Data,
  input  logic [4:0]  IDRs1,
  input  logic [4:0]  IDRs2,
  input  logic [4:0]  IDRd,
  input  logic [1:0]  IDALUOp,
  input  logic [2:0]  IDFunct3,
  input  logic        IDFunct7b5,
  input  logic        IDALUSrc,
  input  logic        IDRegWrite,
  input  logic        IDMemRead,
  input  logic        IDMemWrite,
  input  logic        IDMemToReg,
  input  logic        IDBranch,
  input  logic        Flush,
  input  logic        MEMRegWrite,
  input  logic [4:0]  MEMRd,
  input  logic [31:0] MEMALUOut,
  input  logic        WBRegWrite,
  input  logic [4:0]  WBRd,
  input  logic [31:0] WBData,
  output logic        Stall,
  output logic [3:0]  ALUctl,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] StoreData,
  output logic        EXValid,
  output logic        EXRegWrite,
  output logic        EXMemRead,
  output logic        EXMemWrite,
  output logic        EXMemToReg,
  output logic        EXBranch,
  output logic [4:0]  EXRd,
  output logic [31:0] EXPC,
  output logic [31:0] EXImm
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
  } idex_t;

  idex_t idex_reg;
  idex_t idex_next;

  // A load in EX whose destination feeds the instruction in ID must wait a cycle.
  assign Stall = !Flush && IDValid && idex_reg.valid && idex_reg.mem_read &&
                 (idex_reg.rd != 5'd0) &&
                 ((idex_reg.rd == IDRs1) || (idex_reg.rd == IDRs2));

  always_comb begin
    idex_next = '0;
    if (!Flush && !Stall) begin
      idex_next.valid      = IDValid;
      idex_next.pc         = IDPC;
      idex_next.imm        = IDImm;
      idex_next.rs1_data   = IDRs1Data;
      idex_next.rs2_data   = IDRs2Data;
      idex_next.rs1        = IDRs1;
      idex_next.rs2        = IDRs2;
      idex_next.rd         = IDRd;
      idex_next.alu_op     = IDALUOp;
      idex_next.funct3     = IDFunct3;
      idex_next.funct7b5   = IDFunct7b5;
      idex_next.alu_src    = IDALUSrc;
      idex_next.reg_write  = IDRegWrite;
      idex_next.mem_read   = IDMemRead;
      idex_next.mem_write  = IDMemWrite;
      idex_next.mem_to_reg = IDMemToReg;
      idex_next.branch     = IDBranch;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idex_reg <= '0;
    end else begin
      idex_reg <= idex_next;
    end
  end

  always_comb begin
    ALUctl = 4'b0010;
    case (idex_reg.alu_op)
      2'b00: ALUctl = 4'b0010;
      2'b01: ALUctl = (idex_reg.funct3 == 3'b100) ? 4'b0111 : 4'b0110;
      default: begin
        case (idex_reg.funct3)
          3'b000: ALUctl = (idex_reg.alu_op == 2'b10 && idex_reg.funct7b5) ? 4'b0110 : 4'b0010;
          3'b111: ALUctl = 4'b0000;
          3'b110: ALUctl = 4'b0001;
          3'b010: ALUctl = 4'b0111;
          default: ALUctl = 4'b1111;
        endcase
      end
    endcase
  end

  // One forwarding mux per source operand; the younger MEM result beats WB.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [4:0]  idx;
      logic [31:0] latched;
      logic [31:0] sel;
      assign idx     = (gi == 0) ? idex_reg.rs1 : idex_reg.rs2;
      assign latched = (gi == 0) ? idex_reg.rs1_data : idex_reg.rs2_data;
      always_comb begin
        sel = latched;
        if (MEMRegWrite && (MEMRd != 5'd0) && (MEMRd == idx)) begin
          sel = MEMALUOut;
        end else if (WBRegWrite && (WBRd != 5'd0) && (WBRd == idx)) begin
          sel = WBData;
        end
      end
    end
  endgenerate

  assign A          = g_fwd[0].sel;
  assign StoreData  = g_fwd[1].sel;
  assign B          = idex_reg.alu_src ? idex_reg.imm : g_fwd[1].sel;

  assign EXValid    = idex_reg.valid;
  assign EXRegWrite = idex_reg.reg_write;
  assign EXMemRead  = idex_reg.mem_read;
  assign EXMemWrite = idex_reg.mem_write;
  assign EXMemToReg = idex_reg.mem_to_reg;
  assign EXBranch   = idex_reg.branch;
  assign EXRd       = idex_reg.rd;
  assign EXPC       = idex_reg.pc;
  assign EXImm      = idex_reg.imm;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: a rule-level model of the ID/EX stage checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ex_issue_stage;

  logic        clock, reset;
  logic        IDValid;
  logic [31:0] IDPC, IDImm, IDRs1Data, IDRs2Data;
  logic [4:0]  IDRs1, IDRs2, IDRd;
  logic [1:0]  IDALUOp;
  logic [2:0]  IDFunct3;
  logic        IDFunct7b5, IDALUSrc, IDRegWrite, IDMemRead, IDMemWrite, IDMemToReg, IDBranch;
  logic        Flush, MEMRegWrite, WBRegWrite;
  logic [4:0]  MEMRd, WBRd;
  logic [31:0] MEMALUOut, WBData;
  logic        Stall;
  logic [3:0]  ALUctl;
  logic [31:0] A, B, StoreData;
  logic        EXValid, EXRegWrite, EXMemRead, EXMemWrite, EXMemToReg, EXBranch;
  logic [4:0]  EXRd;
  logic [31:0] EXPC, EXImm;

  ex_issue_stage dut (
    .clock(clock), .reset(reset), .IDValid(IDValid), .IDPC(IDPC), .IDImm(IDImm),
    .IDRs1Data(IDRs1Data), .IDRs2Data(IDRs2Data), .IDRs1(IDRs1), .IDRs2(IDRs2), .IDRd(IDRd),
    .IDALUOp(IDALUOp), .IDFunct3(IDFunct3), .IDFunct7b5(IDFunct7b5), .IDALUSrc(IDALUSrc),
    .IDRegWrite(IDRegWrite), .IDMemRead(IDMemRead), .IDMemWrite(IDMemWrite),
    .IDMemToReg(IDMemToReg), .IDBranch(IDBranch), .Flush(Flush),
    .MEMRegWrite(MEMRegWrite), .MEMRd(MEMRd), .MEMALUOut(MEMALUOut),
    .WBRegWrite(WBRegWrite), .WBRd(WBRd), .WBData(WBData),
    .Stall(Stall), .ALUctl(ALUctl), .A(A), .B(B), .StoreData(StoreData),
    .EXValid(EXValid), .EXRegWrite(EXRegWrite), .EXMemRead(EXMemRead),
    .EXMemWrite(EXMemWrite), .EXMemToReg(EXMemToReg), .EXBranch(EXBranch),
    .EXRd(EXRd), .EXPC(EXPC), .EXImm(EXImm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: what the instruction sitting in EX must look like.
  typedef struct {
    logic        valid;
    logic [31:0] pc, imm, d1, d2;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        b5, alusrc, rw, mr, mw, m2r, br;
  } ex_t;

  ex_t m;

  function automatic logic model_stall();
    return !Flush && IDValid && m.valid && m.mr && (m.rd != 0) &&
           ((m.rd == IDRs1) || (m.rd == IDRs2));
  endfunction

  function automatic logic [3:0] model_alu(input logic [1:0] op, input logic [2:0] f3, input logic b5);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return (f3 == 3'b100) ? 4'b0111 : 4'b0110;
    case (f3)
      3'b000:  return (op == 2'b10 && b5) ? 4'b0110 : 4'b0010;
      3'b111:  return 4'b0000;
      3'b110:  return 4'b0001;
      3'b010:  return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_fwd(input logic [4:0] idx, input logic [31:0] dflt);
    if (MEMRegWrite && MEMRd != 0 && MEMRd == idx) return MEMALUOut;
    if (WBRegWrite && WBRd != 0 && WBRd == idx) return WBData;
    return dflt;
  endfunction

  always @(posedge clock or posedge reset) begin
    ex_t n;
    n = '{default: 0};
    if (!reset && !Flush && !model_stall()) begin
      n.valid = IDValid;  n.pc = IDPC;      n.imm = IDImm;
      n.d1 = IDRs1Data;   n.d2 = IDRs2Data;
      n.rs1 = IDRs1;      n.rs2 = IDRs2;    n.rd = IDRd;
      n.op = IDALUOp;     n.f3 = IDFunct3;  n.b5 = IDFunct7b5;
      n.alusrc = IDALUSrc; n.rw = IDRegWrite; n.mr = IDMemRead;
      n.mw = IDMemWrite;  n.m2r = IDMemToReg; n.br = IDBranch;
    end
    m <= n;
  end

  always @(negedge clock) begin
    chk("stall", Stall, model_stall());
    chk("aluctl", ALUctl, model_alu(m.op, m.f3, m.b5));
    chk("a", A, model_fwd(m.rs1, m.d1));
    chk("b", B, m.alusrc ? m.imm : model_fwd(m.rs2, m.d2));
    chk("storedata", StoreData, model_fwd(m.rs2, m.d2));
    chk("ex_ctl", {EXValid, EXRegWrite, EXMemRead, EXMemWrite, EXMemToReg, EXBranch},
        {m.valid, m.rw, m.mr, m.mw, m.m2r, m.br});
    chk("ex_rd", EXRd, m.rd);
    chk("ex_pc", EXPC, m.pc);
    chk("ex_imm", EXImm, m.imm);
  end

  logic [31:0] pc_ctr = 32'h1000;

  task automatic set_id(input logic v, input logic [1:0] op, input logic [2:0] f3, input logic b5,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic src, input logic rw, input logic mr, input logic mw);
    pc_ctr = pc_ctr + 32'd4;
    IDValid = v; IDALUOp = op; IDFunct3 = f3; IDFunct7b5 = b5;
    IDRs1 = r1; IDRs2 = r2; IDRd = rd; IDRs1Data = d1; IDRs2Data = d2; IDImm = imm;
    IDALUSrc = src; IDRegWrite = rw; IDMemRead = mr; IDMemWrite = mw;
    IDMemToReg = mr; IDBranch = (op == 2'b01); IDPC = pc_ctr;
  endtask

  task automatic set_fwd(input logic mw, input logic [4:0] md, input logic [31:0] mo,
                         input logic ww, input logic [4:0] wd, input logic [31:0] wdat);
    MEMRegWrite = mw; MEMRd = md; MEMALUOut = mo;
    WBRegWrite = ww; WBRd = wd; WBData = wdat;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; Flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    step(); step();
    reset = 1'b0;

    // R-type sub x?, x5, x6 with rs1 forwarded from MEM
    set_id(1, 2'b10, 3'b000, 1, 5, 6, 10, 32'h11, 32'h22, 32'h0, 0, 1, 0, 0);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(1, 5, 32'h64, 0, 0, 0);
    @(negedge clock);
    chk("sub_aluctl", ALUctl, 4'b0110);
    chk("sub_a_fwd_mem", A, 32'h64);
    chk("sub_b_latched", B, 32'h22);

    // MEM vs WB on the same source: MEM wins; MEMRd = 0 falls back to WB
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 2'b10, 3'b000, 0, 1, 7, 11, 32'h5, 32'h99, 32'h0, 0, 1, 0, 0);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(1, 7, 32'h1, 1, 7, 32'h2);
    @(negedge clock);
    chk("prio_b_mem", B, 32'h1);
    set_fwd(1, 0, 32'h1, 1, 7, 32'h2);
    #1;
    chk("prio_b_wb", B, 32'h2);

    // lw x3, 8(x2) then add x4, x3, x1: one bubble, then WB forwarding
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 2'b00, 3'b010, 0, 2, 0, 3, 32'h100, 0, 32'h8, 1, 1, 1, 0);
    step();
    set_id(1, 2'b10, 3'b000, 0, 3, 1, 4, 32'hdead, 32'h5, 32'h0, 0, 1, 0, 0);
    @(negedge clock);
    chk("lu_stall", Stall, 1'b1);
    step();
    set_fwd(1, 3, 32'h108, 0, 0, 0);
    @(negedge clock);
    chk("lu_stall_drops", Stall, 1'b0);
    chk("lu_bubble_valid", EXValid, 1'b0);
    chk("lu_bubble_aluctl", ALUctl, 4'b0010);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 1, 3, 32'h1234);
    @(negedge clock);
    chk("lu_add_valid", EXValid, 1'b1);
    chk("lu_add_rd", EXRd, 5'd4);
    chk("lu_add_a_wb", A, 32'h1234);
    chk("lu_add_b", B, 32'h5);

    // Flush while a load-use hazard is pending
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 2'b00, 3'b010, 0, 2, 0, 3, 32'h100, 0, 32'h8, 1, 1, 1, 0);
    step();
    set_id(1, 2'b10, 3'b000, 0, 3, 1, 4, 32'hdead, 32'h5, 32'h0, 0, 1, 0, 0);
    Flush = 1'b1;
    @(negedge clock);
    chk("flush_stall", Stall, 1'b0);
    step();
    Flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("flush_bubble", EXValid, 1'b0);

    // ALU control corners
    set_id(1, 2'b01, 3'b100, 0, 1, 2, 0, 32'h3, 32'h4, 32'h20, 0, 0, 0, 0);
    step();
    @(negedge clock);
    chk("blt_aluctl", ALUctl, 4'b0111);
    set_id(1, 2'b01, 3'b000, 0, 1, 2, 0, 32'h3, 32'h4, 32'h20, 0, 0, 0, 0);
    step();
    @(negedge clock);
    chk("beq_aluctl", ALUctl, 4'b0110);
    set_id(1, 2'b11, 3'b001, 1, 1, 0, 9, 32'h3, 0, 32'h1, 1, 1, 0, 0);
    step();
    @(negedge clock);
    chk("itype_other_aluctl", ALUctl, 4'b1111);
    set_id(1, 2'b11, 3'b000, 1, 1, 0, 9, 32'h3, 0, 32'h1, 1, 1, 0, 0);
    step();
    @(negedge clock);
    chk("addi_b5_ignored", ALUctl, 4'b0010);
    chk("addi_b_imm", B, 32'h1);

    // Store depending on a load two instructions earlier: WB data, no stall
    set_id(1, 2'b00, 3'b010, 0, 2, 0, 3, 32'h200, 0, 32'h0, 1, 1, 1, 0);
    step();
    set_id(1, 2'b11, 3'b000, 0, 1, 0, 9, 32'h7, 0, 32'h1, 1, 1, 0, 0);
    step();
    set_id(1, 2'b00, 3'b010, 0, 2, 3, 0, 32'h300, 32'hbad, 32'hc, 1, 0, 0, 1);
    @(negedge clock);
    chk("store_no_stall", Stall, 1'b0);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(1, 9, 32'h55, 1, 3, 32'hcafe);
    @(negedge clock);
    chk("store_data_wb", StoreData, 32'hcafe);
    chk("store_b_imm", B, 32'hc);

    // Reset asserted mid-stall clears everything before the next edge
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 2'b00, 3'b010, 0, 2, 0, 3, 32'h100, 0, 32'h8, 1, 1, 1, 0);
    step();
    set_id(1, 2'b10, 3'b000, 0, 1, 3, 4, 32'h1, 32'h2, 32'h0, 0, 1, 0, 0);
    #1;
    chk("pre_reset_stall", Stall, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_stall", Stall, 1'b0);
    chk("rst_valid", EXValid, 1'b0);
    chk("rst_memread", EXMemRead, 1'b0);
    chk("rst_aluctl", ALUctl, 4'b0010);
    chk("rst_a", A, 32'h0);
    chk("rst_b", B, 32'h0);
    chk("rst_storedata", StoreData, 32'h0);
    step();
    reset = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
